// File: rtl/comparador_serial_izq_der.sv
// Serial unsigned magnitude comparator. Latches two K-bit operands on start and
// scans one bit pair per clock, MSB-first (dir=0) or LSB-first (dir=1).
// After exactly K scan cycles it publishes A>B / A<B / A==B with a one-cycle done pulse.
module comparador_serial_izq_der #(
  parameter int unsigned K = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       dir,
  input  logic [K-1:0]               A_valor,
  input  logic [K-1:0]               B_valor,
  output logic                       busy,
  output logic                       done,
  output logic                       A_mayor,
  output logic                       B_mayor,
  output logic                       iguales,
  output logic [$clog2(K+1)-1:0]     bit_cnt
);

  localparam int unsigned CW = $clog2(K + 1);
  localparam logic [CW-1:0] LastCnt = CW'(K - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e         state;
  logic [K-1:0]   a_sh;
  logic [K-1:0]   b_sh;
  logic           dir_q;
  logic           decided_q;
  logic           gt_q;
  logic           lt_q;

  logic           a_bit;
  logic           b_bit;
  logic           gt_d;
  logic           lt_d;
  logic           decided_d;

  // Compare the current bit pair and fold it into the running verdict.
  always_comb begin
    a_bit     = dir_q ? a_sh[0] : a_sh[K-1];
    b_bit     = dir_q ? b_sh[0] : b_sh[K-1];
    gt_d      = gt_q;
    lt_d      = lt_q;
    decided_d = decided_q;
    // MSB-first: first difference is final. LSB-first: last difference wins.
    if (a_bit != b_bit) begin
      if (dir_q || !decided_q) begin
        gt_d      = a_bit;
        lt_d      = b_bit;
        decided_d = 1'b1;
      end
    end
  end

  // Control FSM with registered outputs; running verdict stays internal until the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      a_sh      <= '0;
      b_sh      <= '0;
      dir_q     <= 1'b0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      A_mayor   <= 1'b0;
      B_mayor   <= 1'b0;
      iguales   <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            a_sh      <= A_valor;
            b_sh      <= B_valor;
            dir_q     <= dir;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            A_mayor   <= 1'b0;
            B_mayor   <= 1'b0;
            iguales   <= 1'b0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            state     <= StShift;
          end
        end
        StShift: begin
          a_sh      <= dir_q ? (a_sh >> 1) : (a_sh << 1);
          b_sh      <= dir_q ? (b_sh >> 1) : (b_sh << 1);
          gt_q      <= gt_d;
          lt_q      <= lt_d;
          decided_q <= decided_d;
          bit_cnt   <= bit_cnt + CW'(1);
          if (bit_cnt == LastCnt) begin
            A_mayor <= gt_d;
            B_mayor <= lt_d;
            iguales <= ~(gt_d | lt_d);
            done    <= 1'b1;
            state   <= StDone;
          end
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Directed bench for the serial comparator (K=4) with hand-computed expectations.
module tb_comparador_serial_izq_der;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       dir;
  logic [3:0] A_valor;
  logic [3:0] B_valor;
  logic       busy;
  logic       done;
  logic       A_mayor;
  logic       B_mayor;
  logic       iguales;
  logic [2:0] bit_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  comparador_serial_izq_der #(.K(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dir     (dir),
    .A_valor (A_valor),
    .B_valor (B_valor),
    .busy    (busy),
    .done    (done),
    .A_mayor (A_mayor),
    .B_mayor (B_mayor),
    .iguales (iguales),
    .bit_cnt (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance to the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then check the freshly cleared state.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic d,
                          input string tag);
    A_valor = a;
    B_valor = b;
    dir     = d;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check({tag, " busy@start"}, busy, 1);
    check({tag, " cnt@start"}, bit_cnt, 0);
    check({tag, " flags@start"}, {A_mayor, B_mayor, iguales}, 0);
  endtask

  // Wait for done (bounded) and check latency, result and count.
  task automatic finish_op(input int gt, input int lt, input int eq, input string tag);
    int cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, cyc, 4);
    check({tag, " result"}, {A_mayor, B_mayor, iguales}, gt * 4 + lt * 2 + eq);
    check({tag, " cnt"}, bit_cnt, 4);
  endtask

  // After the done cycle: pulse gone, idle, result held.
  task automatic after_done(input int gt, input int lt, input int eq, input string tag);
    tick();
    check({tag, " done_pulse"}, {done, busy}, 0);
    check({tag, " hold"}, {A_mayor, B_mayor, iguales, bit_cnt}, (gt * 4 + lt * 2 + eq) * 8 + 4);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic d,
                        input int gt, input int lt, input int eq, input string tag);
    start_op(a, b, d, tag);
    finish_op(gt, lt, eq, tag);
    after_done(gt, lt, eq, tag);
  endtask

  initial begin
    int pulses;
    reset   = 1'b1;
    start   = 1'b0;
    dir     = 1'b0;
    A_valor = '0;
    B_valor = '0;
    tick();
    tick();
    check("reset outputs", {busy, done, A_mayor, B_mayor, iguales, bit_cnt}, 0);
    reset = 1'b0;
    tick();
    check("idle no start", {busy, done}, 0);

    // Equal operands, both directions.
    run_op(4'b1111, 4'b1111, 1'b0, 0, 0, 1, "eq_d0");
    run_op(4'b1111, 4'b1111, 1'b1, 0, 0, 1, "eq_d1");
    // A wins at bit 2; LSB-first sees B at bit 1 first, then overwritten.
    run_op(4'b1101, 4'b1011, 1'b0, 1, 0, 0, "gt_d0");
    run_op(4'b1101, 4'b1011, 1'b1, 1, 0, 0, "gt_d1");
    run_op(4'b0000, 4'b1011, 1'b0, 0, 1, 0, "lt_d0");
    run_op(4'b0000, 4'b1011, 1'b1, 0, 1, 0, "lt_d1");
    // Low bits favour A, MSB favours B: direction logic must pick B both ways.
    run_op(4'b0111, 4'b1000, 1'b0, 0, 1, 0, "msb_d0");
    run_op(4'b0111, 4'b1000, 1'b1, 0, 1, 0, "msb_d1");

    // Start held/re-pulsed during SHIFT while operand changes.
    start_op(4'b1001, 4'b0110, 1'b0, "iso");
    start   = 1'b1;
    A_valor = 4'b0000;
    dir     = 1'b1;
    pulses  = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 2) start = 1'b0;
      if (i == 3) start = 1'b1;
      if (i == 4) begin
        check("iso done_at_4", done, 1);
        check("iso result", {A_mayor, B_mayor, iguales}, 4);
        start = 1'b0;
      end
      if (done) pulses++;
    end
    check("iso pulses", pulses, 1);
    check("iso idle", busy, 0);

    // Reset two cycles into an operation.
    start_op(4'b0000, 4'b1011, 1'b0, "rst");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst outputs", {busy, done, A_mayor, B_mayor, iguales, bit_cnt}, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("rst no_done", pulses, 0);
    run_op(4'b1010, 4'b0101, 1'b1, 1, 0, 0, "rst_fresh");

    // Back-to-back: second start in the first IDLE cycle after done.
    start_op(4'b0011, 4'b0011, 1'b0, "b2b1");
    finish_op(0, 0, 1, "b2b1");
    tick();
    check("b2b idle", {done, busy}, 0);
    start_op(4'b0100, 4'b0101, 1'b1, "b2b2");
    finish_op(0, 1, 0, "b2b2");
    after_done(0, 1, 0, "b2b2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
